snowflake_mtimer: RTL and testbench

// - Memory-mapped RISC-V machine timer (mtime/mtimecmp) on the snowflake system register bus.
// - Sits beside the GPIO/7-segment register file on the sys_* port of the system bus.
// - Drives the core's timer_interrupt input, which is currently tied low.
// - Provides a prescaled 64-bit free-running counter plus compare, accessed through 32-bit registers.

---
 rtl/snowflake_mtimer_pkg.sv | 20 ++
 rtl/snowflake_prescaler.sv | 37 +++
 rtl/snowflake_mtimer.sv | 134 +++++++++++++
 tb/tb_snowflake_mtimer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snowflake_mtimer_pkg.sv
// snowflake_mtimer_pkg
// Shared definitions for the snowflake machine timer.
// - Register offsets are the word index taken from sys_addr[4:2].
// - CTRL bit positions.
// - Reset value of the 64-bit compare register.
package snowflake_mtimer_pkg;

    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_PRESC    = 3'd1;
    localparam logic [2:0] TMR_MTIME_LO = 3'd2;
    localparam logic [2:0] TMR_MTIME_HI = 3'd3;
    localparam logic [2:0] TMR_CMP_LO   = 3'd4;
    localparam logic [2:0] TMR_CMP_HI   = 3'd5;

    localparam int CTRL_RUN   = 0;
    localparam int CTRL_IRQEN = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/snowflake_prescaler.sv
// snowflake_prescaler
// Divides the system clock down to the mtime increment rate.
// Ports:
//   clk    in   system clock
//   rstz   in   synchronous active-low reset
//   run    in   count enable (already gated by a same-cycle CTRL write)
//   clear  in   restart the count at 0; suppresses the tick in this cycle
//   presc  in   reload value; a tick fires every presc+1 enabled cycles
//   tick   out  combinational one-cycle increment request for mtime
module snowflake_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rstz,
    input  logic               run,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;
    logic               hit;

    assign hit  = (cnt == presc);
    assign tick = run & ~clear & hit;

    always_ff @(posedge clk) begin
        if (!rstz) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= hit ? '0 : cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/snowflake_mtimer.sv
// snowflake_mtimer
// RISC-V style machine timer (mtime / mtimecmp) on the snowflake system
// register bus, mapped at byte window 0x40-0x5F when BASE_SEL = 2.
// Ports:
//   clk              in   system clock
//   rstz             in   synchronous active-low reset
//   sys_addr         in   byte address, bits [7:2] decoded
//   sys_wr_data      in   write data
//   sys_en           in   access strobe, one cycle per access
//   sys_wr_en        in   1 = write, 0 = read
//   tmr_rd_data      out  registered read data, 0 when not answering a read
//   timer_interrupt  out  registered level interrupt (irq_en & mtime >= mtimecmp)
module snowflake_mtimer
    import snowflake_mtimer_pkg::*;
#(
    parameter logic [2:0] BASE_SEL = 3'd2,
    parameter int         PRESC_W  = 16
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wr_data,
    input  logic        sys_en,
    input  logic        sys_wr_en,
    output logic [31:0] tmr_rd_data,
    output logic        timer_interrupt
);

    logic               sel;
    logic               wr;
    logic               rd;
    logic [2:0]         offset;
    logic [1:0]         ctrl;
    logic [PRESC_W-1:0] presc;
    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic [31:0]        hi_shadow;
    logic [31:0]        rd_mux;
    logic               run_eff;
    logic               tick;
    logic               unused_addr_bits;

    assign sel    = sys_en & (sys_addr[7:5] == BASE_SEL);
    assign wr     = sel & sys_wr_en;
    assign rd     = sel & ~sys_wr_en;
    assign offset = sys_addr[4:2];

    assign unused_addr_bits = &{1'b0, sys_addr[31:8], sys_addr[1:0]};

    // A CTRL write that clears run takes effect in its own cycle, so the
    // prescaler neither advances nor ticks on that edge.
    assign run_eff = ctrl[CTRL_RUN]
                   & ~(wr && offset == TMR_CTRL && !sys_wr_data[CTRL_RUN]);

    snowflake_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rstz  (rstz),
        .run   (run_eff),
        .clear (wr && offset == TMR_PRESC),
        .presc (presc),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstz) begin
            ctrl  <= '0;
            presc <= '0;
        end else if (wr && offset == TMR_CTRL) begin
            ctrl <= sys_wr_data[1:0];
        end else if (wr && offset == TMR_PRESC) begin
            presc <= sys_wr_data[PRESC_W-1:0];
        end
    end

    // A software write to either half wins over a tick in the same cycle;
    // the tick (and any carry into the other half) is dropped.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            mtime <= '0;
        end else if (wr && offset == TMR_MTIME_LO) begin
            mtime[31:0] <= sys_wr_data;
        end else if (wr && offset == TMR_MTIME_HI) begin
            mtime[63:32] <= sys_wr_data;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            mtimecmp <= MTIMECMP_RST;
        end else if (wr && offset == TMR_CMP_LO) begin
            mtimecmp[31:0] <= sys_wr_data;
        end else if (wr && offset == TMR_CMP_HI) begin
            mtimecmp[63:32] <= sys_wr_data;
        end
    end

    // Reading MTIME_LO snapshots the upper half so a following MTIME_HI
    // read forms a consistent 64-bit value.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            hi_shadow <= '0;
        end else if (rd && offset == TMR_MTIME_LO) begin
            hi_shadow <= mtime[63:32];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            TMR_CTRL:     rd_mux = {30'd0, ctrl};
            TMR_PRESC:    rd_mux = 32'(presc);
            TMR_MTIME_LO: rd_mux = mtime[31:0];
            TMR_MTIME_HI: rd_mux = hi_shadow;
            TMR_CMP_LO:   rd_mux = mtimecmp[31:0];
            TMR_CMP_HI:   rd_mux = mtimecmp[63:32];
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            tmr_rd_data     <= '0;
            timer_interrupt <= 1'b0;
        end else begin
            tmr_rd_data     <= rd ? rd_mux : 32'd0;
            timer_interrupt <= ctrl[CTRL_IRQEN] & (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_snowflake_mtimer.sv
// tb_snowflake_mtimer
// Directed bench for snowflake_mtimer. Every task starts and ends just
// after a falling clock edge; inputs change there and outputs are sampled
// there, half a period away from the active rising edge.
module tb_snowflake_mtimer;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic [31:0] sys_addr = '0;
    logic [31:0] sys_wr_data = '0;
    logic        sys_en = 1'b0;
    logic        sys_wr_en = 1'b0;
    logic [31:0] tmr_rd_data;
    logic        timer_interrupt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snowflake_mtimer dut (
        .clk             (clk),
        .rstz            (rstz),
        .sys_addr        (sys_addr),
        .sys_wr_data     (sys_wr_data),
        .sys_en          (sys_en),
        .sys_wr_en       (sys_wr_en),
        .tmr_rd_data     (tmr_rd_data),
        .timer_interrupt (timer_interrupt)
    );

    localparam logic [2:0] O_CTRL = 3'd0, O_PRESC = 3'd1, O_LO = 3'd2, O_HI = 3'd3,
                           O_CLO = 3'd4, O_CHI = 3'd5;

    function automatic logic [31:0] ra(input logic [2:0] off);
        return 32'h40 + {27'd0, off, 2'b00};
    endfunction

    task automatic wr_raw(input logic [31:0] addr, input logic [31:0] data);
        sys_en = 1'b1; sys_wr_en = 1'b1; sys_addr = addr; sys_wr_data = data;
        @(negedge clk);
        sys_en = 1'b0; sys_wr_en = 1'b0;
    endtask

    task automatic rd_raw(input logic [31:0] addr, output logic [31:0] data);
        sys_en = 1'b1; sys_wr_en = 1'b0; sys_addr = addr;
        @(negedge clk);
        sys_en = 1'b0;
        data = tmr_rd_data;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] data);
        wr_raw(ra(off), data);
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] data);
        rd_raw(ra(off), data);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [31:0] exp [8];
        exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
        rstz = 1'b0;
        repeat (3) @(negedge clk);
        rstz = 1'b1;
        total++;
        if (timer_interrupt !== 1'b0) begin
            bad++; $display("FAIL reset_irq: got %b want 0", timer_interrupt);
        end
        total++;
        if (tmr_rd_data !== 32'h0) begin
            bad++; $display("FAIL reset_rd_data: got %h want 0", tmr_rd_data);
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            total++;
            if (v !== exp[i]) begin
                bad++; $display("FAIL reset_reg%0d: got %h want %h", i, v, exp[i]);
            end
        end
    endtask

    task automatic test_prescale;
        logic [31:0] v;
        wr(O_PRESC, 32'd3);
        wr(O_CTRL, 32'd1);
        repeat (40) @(negedge clk);
        rd(O_LO, v);
        total++;
        if (v !== 32'd10) begin
            bad++; $display("FAIL presc3_count: got %0d want 10", v);
        end
        wr(O_PRESC, 32'd0);
        rd(O_LO, v);
        total++;
        if (v !== 32'd10) begin
            bad++; $display("FAIL presc_write_no_tick: got %0d want 10", v);
        end
        rd(O_LO, v);
        total++;
        if (v !== 32'd11) begin
            bad++; $display("FAIL presc0_step1: got %0d want 11", v);
        end
        rd(O_LO, v);
        total++;
        if (v !== 32'd12) begin
            bad++; $display("FAIL presc0_step2: got %0d want 12", v);
        end
        wr(O_CTRL, 32'd0);
        rd(O_LO, v);
        total++;
        if (v !== 32'd13) begin
            bad++; $display("FAIL stop_write_wins: got %0d want 13", v);
        end
        rd(O_LO, v);
        total++;
        if (v !== 32'd13) begin
            bad++; $display("FAIL stopped_frozen: got %0d want 13", v);
        end
    endtask

    task automatic test_carry;
        logic [31:0] v;
        wr(O_LO, 32'hFFFF_FFFF);
        wr(O_HI, 32'h0);
        wr(O_PRESC, 32'd0);
        wr(O_CTRL, 32'd1);
        repeat (2) @(negedge clk);
        wr(O_CTRL, 32'd0);
        rd(O_LO, v);
        total++;
        if (v !== 32'd1) begin
            bad++; $display("FAIL carry_lo: got %h want 1", v);
        end
        rd(O_HI, v);
        total++;
        if (v !== 32'd1) begin
            bad++; $display("FAIL carry_hi: got %h want 1", v);
        end
        rd(O_LO, v);
        wr(O_HI, 32'd7);
        rd(O_HI, v);
        total++;
        if (v !== 32'd1) begin
            bad++; $display("FAIL shadow_not_live: got %h want 1", v);
        end
    endtask

    task automatic test_wrap_irq;
        logic [31:0] v;
        wr(O_LO, 32'hFFFF_FFFF);
        wr(O_HI, 32'hFFFF_FFFF);
        wr(O_CTRL, 32'd1);
        @(negedge clk);
        wr(O_CTRL, 32'd0);
        rd(O_LO, v);
        total++;
        if (v !== 32'd0) begin
            bad++; $display("FAIL wrap_lo: got %h want 0", v);
        end
        rd(O_HI, v);
        total++;
        if (v !== 32'd0) begin
            bad++; $display("FAIL wrap_hi: got %h want 0", v);
        end
        wr(O_CLO, 32'd5);
        wr(O_CHI, 32'd0);
        wr(O_CTRL, 32'd3);
        for (int k = 0; k < 8; k++) begin
            total++;
            if (timer_interrupt !== (k >= 6)) begin
                bad++; $display("FAIL irq_rise_k%0d: got %b want %b", k, timer_interrupt, (k >= 6));
            end
            @(negedge clk);
        end
        wr(O_CTRL, 32'd1);
        total++;
        if (timer_interrupt !== 1'b1) begin
            bad++; $display("FAIL irq_clear_latency: got %b want 1", timer_interrupt);
        end
        @(negedge clk);
        total++;
        if (timer_interrupt !== 1'b0) begin
            bad++; $display("FAIL irq_cleared: got %b want 0", timer_interrupt);
        end
        wr(O_CTRL, 32'd0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        wr(O_CTRL, 32'd1);
        wr(O_LO, 32'd100);
        wr(O_CTRL, 32'd0);
        rd(O_LO, v);
        total++;
        if (v !== 32'd100) begin
            bad++; $display("FAIL write_beats_tick: got %0d want 100", v);
        end
        rd(O_HI, v);
        total++;
        if (v !== 32'd0) begin
            bad++; $display("FAIL write_no_carry_hi: got %h want 0", v);
        end
        wr(O_PRESC, 32'd4);
        wr(O_CTRL, 32'd1);
        repeat (3) @(negedge clk);
        wr(O_PRESC, 32'd2);
        repeat (2) @(negedge clk);
        rd(O_LO, v);
        total++;
        if (v !== 32'd100) begin
            bad++; $display("FAIL presc_mid_before: got %0d want 100", v);
        end
        rd(O_LO, v);
        total++;
        if (v !== 32'd101) begin
            bad++; $display("FAIL presc_mid_tick: got %0d want 101", v);
        end
        wr(O_CTRL, 32'd0);
    endtask

    task automatic test_unselected;
        logic [31:0] v;
        wr_raw(32'h0000_0008, 32'h55);
        wr_raw(32'h0000_0060, 32'h3);
        wr_raw(32'h0000_0088, 32'h77);
        rd_raw(32'h0000_0008, v);
        total++;
        if (v !== 32'd0) begin
            bad++; $display("FAIL unsel_rd_zero: got %h want 0", v);
        end
        rd(O_LO, v);
        total++;
        if (v !== 32'd101) begin
            bad++; $display("FAIL unsel_no_mtime_change: got %h want 101", v);
        end
        rd(O_CTRL, v);
        total++;
        if (v !== 32'd0) begin
            bad++; $display("FAIL unsel_no_ctrl_change: got %h want 0", v);
        end
        @(negedge clk);
        total++;
        if (tmr_rd_data !== 32'd0) begin
            bad++; $display("FAIL idle_rd_zero: got %h want 0", tmr_rd_data);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] v;
        logic [31:0] exp [8];
        exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
        wr(O_HI, 32'd9);
        rd(O_LO, v);
        wr(O_PRESC, 32'd0);
        wr(O_CTRL, 32'd3);
        repeat (2) @(negedge clk);
        total++;
        if (timer_interrupt !== 1'b1) begin
            bad++; $display("FAIL prereset_irq: got %b want 1", timer_interrupt);
        end
        rstz = 1'b0;
        @(negedge clk);
        total++;
        if (timer_interrupt !== 1'b0) begin
            bad++; $display("FAIL midreset_irq: got %b want 0", timer_interrupt);
        end
        rstz = 1'b1;
        rd(O_HI, v);
        total++;
        if (v !== 32'd0) begin
            bad++; $display("FAIL midreset_shadow: got %h want 0", v);
        end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            total++;
            if (v !== exp[i]) begin
                bad++; $display("FAIL midreset_reg%0d: got %h want %h", i, v, exp[i]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_prescale();
        test_carry();
        test_wrap_irq();
        test_back_to_back();
        test_unselected();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
